// File: rtl/recv_b_pkg.sv
// recv_b_pkg: shared state encoding, error bit positions and bit-timing helper for recv_b
package recv_b_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   localparam int ERR_FRM = 0;
   localparam int ERR_PAR = 1;
   localparam int ERR_OVR = 2;
   function automatic int mid_cnt(input int cpb);
      return cpb / 2 - 1;
   endfunction
endpackage

// File: rtl/sync_bit.sv
// sync_bit: multi-flop synchronizer for a single asynchronous input with a selectable reset value
module sync_bit #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] ff;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ff <= {STAGES{RST_VAL}};
      else ff <= {ff[STAGES-2:0], d};
   assign q = ff[STAGES-1];
endmodule

// File: rtl/recv_b.sv
// recv_b: asynchronous serial byte receiver with optional even parity and a one-entry valid/ready holding register
module recv_b
   import recv_b_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter bit PARITY_EN    = 1'b1,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       recv_b_in1,
   input  logic       recv_b_in2,
   input  logic       recv_b_rdy,
   output logic [7:0] recv_b_out1,
   output logic       recv_b_out2,
   output logic [2:0] recv_b_err
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] MID  = CW'(mid_cnt(CLKS_PER_BIT));
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0] idx, idx_n, err_n;
   logic [7:0] shreg, shreg_n;
   logic par_bad, par_bad_n, brk, brk_n, line, last, load, full;
   sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (recv_b_in1),
      .q    (line)
   );
   assign last = cnt == LAST;
   assign full = recv_b_out2 && !recv_b_rdy;
   // brk blocks a new start after a framing error until the line has gone back high
   always_comb begin
      state_n   = state;
      cnt_n     = last ? '0 : cnt + 1'b1;
      idx_n     = idx;
      shreg_n   = shreg;
      par_bad_n = par_bad;
      brk_n     = brk & ~line;
      err_n     = '0;
      load      = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (recv_b_in2 && !line && !brk) state_n = START;
         end
         START: if (cnt == MID) begin
            state_n   = line ? IDLE : DATA;
            cnt_n     = '0;
            idx_n     = '0;
            par_bad_n = 1'b0;
         end
         DATA: if (last) begin
            shreg_n[idx] = line;
            idx_n        = idx + 1'b1;
            if (idx == 3'd7) state_n = PARITY_EN ? PARITY : STOP;
         end
         PARITY: if (last) begin
            par_bad_n = line ^ (^shreg);
            state_n   = STOP;
         end
         STOP: if (last) begin
            state_n        = IDLE;
            brk_n          = !line;
            err_n[ERR_FRM] = !line;
            err_n[ERR_PAR] = line && par_bad;
            err_n[ERR_OVR] = line && !par_bad && full;
            load           = line && !par_bad && !full;
         end
         default: state_n = IDLE;
      endcase
      if (!recv_b_in2) begin
         state_n = IDLE;
         cnt_n   = '0;
         err_n   = '0;
         load    = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         idx         <= '0;
         shreg       <= '0;
         par_bad     <= 1'b0;
         brk         <= 1'b0;
         recv_b_out1 <= '0;
         recv_b_out2 <= 1'b0;
         recv_b_err  <= '0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         idx        <= idx_n;
         shreg      <= shreg_n;
         par_bad    <= par_bad_n;
         brk        <= brk_n;
         recv_b_err <= err_n;
         if (load) begin
            recv_b_out1 <= shreg;
            recv_b_out2 <= 1'b1;
         end else if (recv_b_out2 && recv_b_rdy) recv_b_out2 <= 1'b0;
      end
endmodule

// File: tb/tb_recv_b.sv
// tb_recv_b: self-checking bench for recv_b using frame tables, hand-built corner sequences and random frames
module tb_recv_b;
   localparam int CPB  = 16;
   localparam int SYNC = 2;
   localparam int SAMPLE = SYNC + CPB * 21 / 2;
   logic clk = 1'b0, rst_n = 1'b0, line_in = 1'b1, en = 1'b1, rdy = 1'b1;
   logic [7:0] out1;
   logic out2, out2_q = 1'b0;
   logic [2:0] err;
   int checks = 0, failures = 0, cyc = 0, t_start = 0, t_rise = -1;
   typedef struct packed {logic [2:0] e; logic [7:0] d;} ev_t;
   typedef struct {logic [7:0] d; bit pf; bit st; logic [2:0] e; logic [7:0] xd;} vec_t;
   ev_t obs[$];
   vec_t tbl[6];
   recv_b #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .SYNC_STAGES(SYNC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .recv_b_in1 (line_in),
      .recv_b_in2 (en),
      .recv_b_rdy (rdy),
      .recv_b_out1(out1),
      .recv_b_out2(out2),
      .recv_b_err (err)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // observed events: every error pulse and every completed transfer, in order
   always @(negedge clk) begin
      if (err != 3'b000) obs.push_back('{err, 8'h00});
      if (out2 && rdy) obs.push_back('{3'b000, out1});
      if (out2 && !out2_q) t_rise <= cyc;
      out2_q <= out2;
   end
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic send(input logic [7:0] d, input bit pf, input bit st, input int tail = 0);
      logic [10:0] bits;
      bits = {st, (^d) ^ pf, d, 1'b0};
      t_start = cyc;
      for (int i = 0; i < 11; i++) begin
         line_in = bits[i];
         tick(CPB);
      end
      tick(tail * CPB);
      line_in = 1'b1;
      tick(2 * CPB);
   endtask
   task automatic expect_one(input string nm, input logic [2:0] e, input logic [7:0] d);
      check({nm, " count"}, obs.size(), 1);
      if (obs.size() > 0) begin
         check({nm, " err"}, obs[0].e, e);
         check({nm, " data"}, obs[0].d, d);
      end
      obs.delete();
   endtask
   initial begin
      int lat;
      logic [7:0] d;
      bit pf, st;
      tbl[0] = '{8'h5A, 1'b0, 1'b1, 3'b000, 8'h5A};
      tbl[1] = '{8'h01, 1'b1, 1'b1, 3'b010, 8'h00};
      tbl[2] = '{8'hFF, 1'b0, 1'b0, 3'b001, 8'h00};
      tbl[3] = '{8'h80, 1'b1, 1'b0, 3'b001, 8'h00};
      tbl[4] = '{8'h00, 1'b0, 1'b1, 3'b000, 8'h00};
      tbl[5] = '{8'hFF, 1'b0, 1'b1, 3'b000, 8'hFF};
      tick(3);
      check("reset out1", out1, 8'h00);
      check("reset valid", out2, 1'b0);
      check("reset err", err, 3'b000);
      rst_n = 1'b1;
      tick(4);
      for (int i = 0; i < 6; i++) begin
         send(tbl[i].d, tbl[i].pf, tbl[i].st);
         if (i == 0) begin
            lat = t_rise - t_start;
            check("latency", (lat >= SAMPLE && lat <= SAMPLE + 2), 1'b1);
         end
         expect_one($sformatf("table%0d", i), tbl[i].e, tbl[i].xd);
      end
      line_in = 1'b0;
      tick(5);
      line_in = 1'b1;
      tick(3 * CPB);
      check("glitch quiet", obs.size(), 0);
      check("glitch valid", out2, 1'b0);
      send(8'hC3, 1'b0, 1'b1);
      expect_one("after glitch", 3'b000, 8'hC3);
      send(8'h3C, 1'b0, 1'b0, 2);
      expect_one("break", 3'b001, 8'h00);
      send(8'h96, 1'b0, 1'b1);
      expect_one("after break", 3'b000, 8'h96);
      rdy = 1'b0;
      send(8'h11, 1'b0, 1'b1);
      send(8'h22, 1'b0, 1'b1);
      expect_one("overrun", 3'b100, 8'h00);
      check("overrun held", out1, 8'h11);
      check("overrun valid", out2, 1'b1);
      rdy = 1'b1;
      tick(1);
      check("overrun drop", out2, 1'b0);
      expect_one("overrun xfer", 3'b000, 8'h11);
      rdy = 1'b0;
      send(8'h44, 1'b0, 1'b1);
      check("held 44", out1, 8'h44);
      fork
         send(8'h33, 1'b0, 1'b1);
         begin
            tick(SAMPLE);
            rdy = 1'b1;
            tick(1);
            rdy = 1'b0;
         end
      join
      expect_one("simul xfer", 3'b000, 8'h44);
      check("simul valid", out2, 1'b1);
      check("simul data", out1, 8'h33);
      rdy = 1'b1;
      tick(2);
      expect_one("simul drain", 3'b000, 8'h33);
      rdy = 1'b0;
      send(8'h66, 1'b0, 1'b1);
      fork
         send(8'h77, 1'b0, 1'b1);
         begin
            tick(5 * CPB + 8);
            en = 1'b0;
         end
      join
      en = 1'b1;
      check("disable quiet", obs.size(), 0);
      check("disable valid", out2, 1'b1);
      check("disable held", out1, 8'h66);
      fork
         send(8'h99, 1'b0, 1'b1);
         begin
            tick(3 * CPB);
            rst_n = 1'b0;
            #1;
            check("midrst valid", out2, 1'b0);
            check("midrst out1", out1, 8'h00);
            check("midrst err", err, 3'b000);
         end
      join
      rst_n = 1'b1;
      rdy = 1'b1;
      tick(2);
      send(8'hA5, 1'b0, 1'b1);
      expect_one("after reset", 3'b000, 8'hA5);
      for (int i = 0; i < 40; i++) begin
         d  = 8'($urandom);
         pf = ($urandom % 4) == 0;
         st = ($urandom % 4) != 0;
         send(d, pf, st);
         expect_one($sformatf("rand%0d", i), !st ? 3'b001 : pf ? 3'b010 : 3'b000, (!st || pf) ? 8'h00 : d);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
